boron_key_inv: RTL

BORON_KEY_INV -- requirements
Module: boron_key_inv

---
 rtl/boron_pkg.sv | 23 ++
 rtl/boron_gate.sv | 8 +
 rtl/boron_inv_gate.sv | 8 +
 rtl/boron_key_inv.sv | 122 ++++++++++++
 4 files changed

// File: rtl/boron_pkg.sv
// Shared definitions for the boron key schedule: sizes, S-box tables and FSM states.
package boron_pkg;
  localparam int ROUNDS     = 25;
  localparam int KEY_ROT    = 13;
  localparam int KEY_W      = 128;
  localparam int RK_W       = 64;
  localparam int RND_W      = 5;
  localparam int SBOX_LANES = 2;   // nibbles [3:0] and [7:4] go through the S-box

  // Forward S-box, indexed by input nibble 0..F.
  localparam logic [3:0] SBOX [16] = '{
    4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
    4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6
  };

  // Inverse S-box, indexed by input nibble 0..F.
  localparam logic [3:0] INV_SBOX [16] = '{
    4'hA, 4'h3, 4'h9, 4'hE, 4'h1, 4'hD, 4'hF, 4'h4,
    4'hC, 4'h5, 4'h7, 4'h2, 4'h6, 4'h8, 4'h0, 4'hB
  };

  typedef enum logic [1:0] {IDLE, FWD, EMIT, DONE} state_t;
endpackage

// File: rtl/boron_gate.sv
// Forward 4-bit S-box lane.
module boron_gate (
  input  logic [3:0] x,
  output logic [3:0] y
);
  import boron_pkg::*;
  assign y = SBOX[x];
endmodule

// File: rtl/boron_inv_gate.sv
// Inverse 4-bit S-box lane; undoes boron_gate.
module boron_inv_gate (
  input  logic [3:0] x,
  output logic [3:0] y
);
  import boron_pkg::*;
  assign y = INV_SBOX[x];
endmodule

// File: rtl/boron_key_inv.sv
// Decryption key sequencer: runs the key schedule forward from K0 to K25, then
// walks it back one round per handshake, emitting RK25 .. RK0.
// Optional build macro BORON_KEY_INV_PRELOAD_EN adds a preload input that lets
// the caller supply K25 directly and skip the forward pass.
module boron_key_inv (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
`ifdef BORON_KEY_INV_PRELOAD_EN
  input  logic         preload,
`endif
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic [63:0]  rk_out,
  output logic         rk_valid,
  output logic [4:0]   rk_round,
  output logic         busy,
  output logic         done
);
  import boron_pkg::*;

  state_t                       state_q, state_d;
  logic [KEY_W-1:0]             key_q, fwd_rot, fwd_key, inv_mix, inv_sub, inv_key;
  logic [RK_W-1:0]              rk_out_q;
  logic [RND_W-1:0]             rnd_q, rnd_dec;
  logic [SBOX_LANES-1:0][3:0]   fwd_nib, inv_nib;
  logic                         pre_sel;

`ifdef BORON_KEY_INV_PRELOAD_EN
  assign pre_sel = preload;
`else
  assign pre_sel = 1'b0;
`endif

  // Forward step: rotate left, substitute the low nibbles, mix in the round index.
  assign fwd_rot = {key_q[KEY_W-1-KEY_ROT:0], key_q[KEY_W-1:KEY_W-KEY_ROT]};
  // Inverse step: unmix the round index first, then substitute and rotate right.
  assign rnd_dec = rnd_q - RND_W'(1);

  genvar g;
  generate
    for (g = 0; g < SBOX_LANES; g++) begin : g_lane
      boron_gate     u_fwd (.x(fwd_rot[4*g +: 4]), .y(fwd_nib[g]));
      boron_inv_gate u_inv (.x(inv_mix[4*g +: 4]), .y(inv_nib[g]));
    end
  endgenerate

  // Assemble forward and inverse round results around the S-box lanes.
  always_comb begin
    fwd_key = fwd_rot;
    fwd_key[4*SBOX_LANES-1:0] = fwd_nib;
    fwd_key[RK_W-1 -: RND_W] = fwd_key[RK_W-1 -: RND_W] ^ rnd_q;
    inv_mix = key_q;
    inv_mix[RK_W-1 -: RND_W] = key_q[RK_W-1 -: RND_W] ^ rnd_dec;
    inv_sub = inv_mix;
    inv_sub[4*SBOX_LANES-1:0] = inv_nib;
    inv_key = {inv_sub[KEY_ROT-1:0], inv_sub[KEY_W-1:KEY_ROT]};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and Moore outputs; start is only looked at in IDLE.
  always_comb begin
    state_d  = state_q;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    rk_valid = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = pre_sel ? EMIT : FWD;
      FWD:  if (rnd_q == RND_W'(ROUNDS-1)) state_d = EMIT;
      EMIT: begin
        rk_valid = 1'b1;
        if (rk_ready && rnd_q == '0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Key/round datapath. rk_out has its own register so it only moves when a
  // new round key becomes current, never during the forward pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q    <= '0;
      rnd_q    <= '0;
      rk_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          key_q <= key_in;
          if (pre_sel) begin
            rnd_q    <= RND_W'(ROUNDS);
            rk_out_q <= key_in[RK_W-1:0];
          end else begin
            rnd_q    <= '0;
          end
        end
        FWD: begin
          key_q <= fwd_key;
          rnd_q <= rnd_q + RND_W'(1);
          if (rnd_q == RND_W'(ROUNDS-1)) rk_out_q <= fwd_key[RK_W-1:0];
        end
        EMIT: if (rk_ready && rnd_q != '0) begin
          key_q    <= inv_key;
          rnd_q    <= rnd_dec;
          rk_out_q <= inv_key[RK_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign rk_out   = rk_out_q;
  assign rk_round = rnd_q;
endmodule
